// File: rtl/psram_data_port_pkg.sv
// Shared types and defaults for the psram data port.
package psram_data_port_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } psram_port_state_e;

  localparam logic [31:0] PSRAM_BASE_ADDR = 32'h4000_0000;

endpackage

// File: rtl/psram_data_port_if.sv
// Core-side load/store request and response bus of the psram data port.
interface psram_data_port_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, stall, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, stall, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/psram_lane_mux.sv
// Byte-lane packing for psram stores and extraction/zero-extension for loads.
module psram_lane_mux
  import psram_data_port_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        addr0,
  input  logic        beat,
  input  logic [31:0] wdata,
  input  logic [15:0] rd_lo,
  input  logic [15:0] rd_hi,
  output logic [15:0] wr_data,
  output logic        wr_hi,
  output logic        wr_lo,
  output logic [31:0] rdata
);
  always_comb begin
    wr_data = beat ? wdata[31:16] : wdata[15:0];
    wr_hi   = 1'b1;
    wr_lo   = 1'b1;
    rdata   = {rd_hi, rd_lo};
    case (size)
      MEM_SIZE_BYTE: begin
        wr_data = {wdata[7:0], wdata[7:0]};
        wr_hi   = addr0;
        wr_lo   = !addr0;
        rdata   = {24'b0, addr0 ? rd_lo[15:8] : rd_lo[7:0]};
      end
      MEM_SIZE_HALF: rdata = {16'b0, rd_lo};
      default: ;
    endcase
  end
endmodule

// File: rtl/psram_data_port.sv
// Core data-memory responder: splits byte/half/word accesses into 16-bit psram beats.
// Optional watchdog per beat: define PSRAM_DATA_PORT_TIMEOUT_EN.
module psram_data_port
  import psram_data_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = PSRAM_BASE_ADDR,
  parameter int          WINDOW_BITS    = 23,
  parameter int          TIMEOUT_CYCLES = 1024
)(
  input  logic               clk,
  input  logic               reset,
  psram_data_port_if.slave   core,
  output logic [21:0]        psram_addr,
  output logic               psram_write_en,
  output logic               psram_read_en,
  output logic [15:0]        psram_data_in,
  output logic               psram_write_high_byte,
  output logic               psram_write_low_byte,
  input  logic               psram_busy,
  input  logic               psram_read_avail,
  input  logic [15:0]        psram_data_out
);
  psram_port_state_e state;
  logic        we_q, addr0_q, beat_q, err_q, seen_busy_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [21:0] haddr_q;
  logic [15:0] rd_lo_q, rd_hi_q;

  logic [31:0] off;
  logic        in_win, legal, tmo_hit, strobe, beat_done, last_beat, resp_valid;
  logic [15:0] mux_wdata;
  logic        mux_hi, mux_lo;
  logic [31:0] mux_rdata;

  assign off    = core.req_addr - BASE_ADDR;
  assign in_win = (off >> WINDOW_BITS) == 32'd0;

  always_comb begin
    legal = 1'b0;
    case (core.req_size)
      MEM_SIZE_BYTE: legal = in_win;
      MEM_SIZE_HALF: legal = in_win && !core.req_addr[0];
      MEM_SIZE_WORD: legal = in_win && (core.req_addr[1:0] == 2'b00);
      default:       legal = 1'b0;
    endcase
  end

`ifdef PSRAM_DATA_PORT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  assign tmo_hit = (state == ISSUE || state == WAIT) &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  // A write beat ends only after the controller has visibly gone busy and idle again.
  assign strobe    = (state == ISSUE) && !psram_busy && !tmo_hit;
  assign beat_done = (state == WAIT) &&
                     (we_q ? (seen_busy_q && !psram_busy) : psram_read_avail);
  assign last_beat = (size_q != MEM_SIZE_WORD) || beat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      addr0_q     <= 1'b0;
      beat_q      <= 1'b0;
      err_q       <= 1'b0;
      seen_busy_q <= 1'b0;
      size_q      <= 2'd0;
      wdata_q     <= '0;
      haddr_q     <= '0;
      rd_lo_q     <= '0;
      rd_hi_q     <= '0;
`ifdef PSRAM_DATA_PORT_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
`ifdef PSRAM_DATA_PORT_TIMEOUT_EN
      if (state == ISSUE || state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
`endif
      case (state)
        IDLE: if (core.req_valid) begin
          we_q    <= core.req_we;
          size_q  <= core.req_size;
          addr0_q <= core.req_addr[0];
          wdata_q <= core.req_wdata;
          haddr_q <= off[22:1];
          beat_q  <= 1'b0;
          rd_lo_q <= '0;
          rd_hi_q <= '0;
          err_q   <= !legal;
          state   <= legal ? ISSUE : RESP;
`ifdef PSRAM_DATA_PORT_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        ISSUE: begin
          if (tmo_hit) begin
            err_q <= 1'b1;
            state <= RESP;
          end else if (!psram_busy) begin
            seen_busy_q <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (beat_done) begin
            if (!we_q) begin
              if (beat_q) rd_hi_q <= psram_data_out;
              else        rd_lo_q <= psram_data_out;
            end
            if (last_beat) state <= RESP;
            else begin
              beat_q <= 1'b1;
              state  <= ISSUE;
`ifdef PSRAM_DATA_PORT_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            state <= RESP;
          end else if (psram_busy) begin
            seen_busy_q <= 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  psram_lane_mux u_lane_mux (
    .size    (size_q),
    .addr0   (addr0_q),
    .beat    (beat_q),
    .wdata   (wdata_q),
    .rd_lo   (rd_lo_q),
    .rd_hi   (rd_hi_q),
    .wr_data (mux_wdata),
    .wr_hi   (mux_hi),
    .wr_lo   (mux_lo),
    .rdata   (mux_rdata)
  );

  assign resp_valid            = (state == RESP);
  assign core.resp_valid       = resp_valid;
  assign core.resp_err         = resp_valid && err_q;
  assign core.resp_rdata       = (resp_valid && !err_q) ? mux_rdata : '0;
  assign core.req_ready        = (state == IDLE);
  assign core.stall            = core.req_valid && !resp_valid;

  assign psram_addr            = haddr_q + {21'b0, beat_q};
  assign psram_write_en        = strobe && we_q;
  assign psram_read_en         = strobe && !we_q;
  assign psram_data_in         = mux_wdata;
  assign psram_write_high_byte = psram_write_en && mux_hi;
  assign psram_write_low_byte  = psram_write_en && mux_lo;
endmodule
